// File: rtl/pid_cfg_ctrl_pkg.sv
// Shared definitions for the PID configuration controller: opcodes, register
// addresses, register reset values, FSM state encoding and a saturating helper.
package pid_cfg_ctrl_pkg;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_COMMIT   = 8'h02;
  localparam logic [7:0] OP_WRCOMMIT = 8'h03;

  localparam logic [1:0] ADDR_KP  = 2'd0;
  localparam logic [1:0] ADDR_KI  = 2'd1;
  localparam logic [1:0] ADDR_KD  = 2'd2;
  localparam logic [1:0] ADDR_SP  = 2'd3;
  localparam logic [7:0] ADDR_MAX = 8'h03;

  localparam logic [7:0] RST_KP = 8'h4A;
  localparam logic [7:0] RST_KI = 8'h23;
  localparam logic [7:0] RST_KD = 8'h00;
  localparam logic [7:0] RST_SP = 8'h10;

  localparam logic [5:0] CNT_MAX = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RECV        = 3'd1,
    ST_CHECK       = 3'd2,
    ST_APPLY       = 3'd3,
    ST_WAIT_COMMIT = 3'd4
  } state_e;

  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [1:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {3'b000, b};
    return (s > 5'd15) ? 4'hF : s[3:0];
  endfunction

endpackage

// File: rtl/pid_cfg_sync.sv
// Two-flop synchronizer for a raw SPI line, with single-cycle rise/fall pulses
// derived from the synchronized copy.
module pid_cfg_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/pid_cfg_ctrl.sv
// SPI-framed configuration controller for PID gains/setpoint with shadow/active
// registers and deferred commit. Optional idle-SCK abort: define PID_CFG_TIMEOUT_EN.
module pid_cfg_ctrl
  import pid_cfg_ctrl_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            sck,
  input  logic [BITS-1:0] frame_word,
  input  logic            pid_busy,
  output logic [7:0]      kp,
  output logic [7:0]      ki,
  output logic [7:0]      kd,
  output logic [7:0]      sp,
  output logic            cfg_valid,
  output logic [3:0]      err_cnt
);

  localparam logic [5:0] BITS_C = 6'(BITS);

  logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;
  logic w_tmo;
  logic w_cnt_clr, w_cnt_inc, w_cap, w_bad, w_drop, w_shadow_wr, w_commit;
  logic w_len_ok;
  logic [7:0] w_op, w_addr;
  logic w_unused;

  state_e     r_state, w_state_nxt;
  logic [5:0] r_cnt;
  logic [7:0] r_op, r_data;
  logic [1:0] r_addr;
  logic [7:0] r_sh_kp, r_sh_ki, r_sh_kd, r_sh_sp;
  logic [7:0] r_kp, r_ki, r_kd, r_sp;
  logic       r_cfg_valid;
  logic [3:0] r_err_cnt;

  pid_cfg_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  pid_cfg_sync #(.RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  assign w_op     = frame_word[31:24];
  assign w_addr   = frame_word[23:16];
  assign w_len_ok = (r_cnt == BITS_C);
  assign w_unused = ^{frame_word[15:8], w_sck_rise};

`ifdef PID_CFG_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] r_tmr;

  // Idle-SCK timer: restarts on every sck edge and whenever not receiving
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmr <= '0;
    end else if ((r_state != ST_RECV) || w_sck_rise || w_sck_fall) begin
      r_tmr <= '0;
    end else if (!w_tmo) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  assign w_tmo = (r_state == ST_RECV) && (r_tmr == TMR_W'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cap       = 1'b0;
    w_bad       = 1'b0;
    w_drop      = 1'b0;
    w_shadow_wr = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_RECV;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RECV: begin
        w_cnt_inc = w_sck_fall;
        if (w_cs_rise) begin
          w_state_nxt = ST_CHECK;
        end else if (w_tmo) begin
          w_state_nxt = ST_IDLE;
          w_bad       = 1'b1;
        end else begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_CHECK: begin
        w_cap  = 1'b1;
        w_drop = w_cs_fall;
        if (!w_len_ok) begin
          w_state_nxt = ST_IDLE;
          w_bad       = 1'b1;
        end else begin
          case (w_op)
            OP_NOP:    w_state_nxt = ST_IDLE;
            OP_COMMIT: w_state_nxt = ST_APPLY;
            OP_WRITE, OP_WRCOMMIT: begin
              if (w_addr <= ADDR_MAX) begin
                w_state_nxt = ST_APPLY;
              end else begin
                w_state_nxt = ST_IDLE;
                w_bad       = 1'b1;
              end
            end
            default: begin
              w_state_nxt = ST_IDLE;
              w_bad       = 1'b1;
            end
          endcase
        end
      end
      ST_APPLY: begin
        w_drop      = w_cs_fall;
        w_shadow_wr = (r_op != OP_COMMIT);
        if (r_op == OP_WRITE) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_COMMIT;
        end
      end
      ST_WAIT_COMMIT: begin
        w_drop = w_cs_fall;
        if (!pid_busy) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_COMMIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit counter, decoded-frame capture and error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 6'd0;
      r_op      <= 8'h00;
      r_addr    <= 2'd0;
      r_data    <= 8'h00;
      r_err_cnt <= 4'd0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= 6'd0;
      end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 6'd1;
      end
      if (w_cap) begin
        r_op   <= w_op;
        r_addr <= w_addr[1:0];
        r_data <= frame_word[7:0];
      end
      r_err_cnt <= sat_add4(r_err_cnt, {1'b0, w_bad} + {1'b0, w_drop});
    end
  end

  // Shadow/active registers; active copies change only on a commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_kp     <= RST_KP;
      r_sh_ki     <= RST_KI;
      r_sh_kd     <= RST_KD;
      r_sh_sp     <= RST_SP;
      r_kp        <= RST_KP;
      r_ki        <= RST_KI;
      r_kd        <= RST_KD;
      r_sp        <= RST_SP;
      r_cfg_valid <= 1'b0;
    end else begin
      if (w_shadow_wr) begin
        case (r_addr)
          ADDR_KP: r_sh_kp <= r_data;
          ADDR_KI: r_sh_ki <= r_data;
          ADDR_KD: r_sh_kd <= r_data;
          ADDR_SP: r_sh_sp <= r_data;
          default: r_sh_kp <= r_sh_kp;
        endcase
      end
      if (w_commit) begin
        r_kp <= r_sh_kp;
        r_ki <= r_sh_ki;
        r_kd <= r_sh_kd;
        r_sp <= r_sh_sp;
      end
      r_cfg_valid <= w_commit;
    end
  end

  assign kp        = r_kp;
  assign ki        = r_ki;
  assign kd        = r_kd;
  assign sp        = r_sp;
  assign cfg_valid = r_cfg_valid;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_pid_cfg_ctrl.sv
// Scoreboard bench for pid_cfg_ctrl: expected active-register sets are queued
// when a committing frame is driven and compared on every cfg_valid pulse.
`timescale 1ns/1ps
module tb_pid_cfg_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b1;
  logic        sck = 1'b0;
  logic [31:0] frame_word = 32'h0;
  logic        pid_busy = 1'b0;
  logic [7:0]  kp, ki, kd, sp;
  logic        cfg_valid;
  logic [3:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb_q[$];

  localparam logic [31:0] RST_REGS = 32'h4A23_0010;

  pid_cfg_ctrl #(.BITS(32), .TIMEOUT(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .sck        (sck),
    .frame_word (frame_word),
    .pid_busy   (pid_busy),
    .kp         (kp),
    .ki         (ki),
    .kd         (kd),
    .sp         (sp),
    .cfg_valid  (cfg_valid),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every cfg_valid pulse must match the oldest queued set
  always @(negedge clk) begin
    if (cfg_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("cfg_unexpected", 32'(cfg_valid), 32'd0);
      end else begin
        check_val("cfg_regs", {kp, ki, kd, sp}, sb_q.pop_front());
      end
    end
  end

  task automatic send_frame(input logic [31:0] word, input int nbits);
    frame_word = word;
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sck = 1'b1;
      repeat (3) @(negedge clk);
      sck = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cs    = 1'b1;
    sck   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_kp", 32'(kp), 32'h4A);
    check_val("rst_ki", 32'(ki), 32'h23);
    check_val("rst_kd", 32'(kd), 32'h00);
    check_val("rst_sp", 32'(sp), 32'h10);
    check_val("rst_err", 32'(err_cnt), 32'd0);
    check_val("rst_cfg", 32'(cfg_valid), 32'd0);

    // Write then separate commit
    send_frame(32'h0100_0055, 32);
    check_val("wr_no_commit_kp", 32'(kp), 32'h4A);
    check_val("wr_err", 32'(err_cnt), 32'd0);
    sb_q.push_back(32'h5523_0010);
    send_frame(32'h0200_0000, 32);
    check_val("commit_kp", 32'(kp), 32'h55);
    check_val("commit_sb", 32'(sb_q.size()), 32'd0);

    // Write+commit held off by pid_busy
    pid_busy = 1'b1;
    sb_q.push_back(32'h5523_7F10);
    send_frame(32'h0302_007F, 32);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("busy_kd_hold", 32'(kd), 32'h00);
    end
    pid_busy = 1'b0;
    repeat (5) @(negedge clk);
    check_val("busy_kd_after", 32'(kd), 32'h7F);

    // Reset mid-frame after 10 bits
    frame_word = 32'h0300_0099;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      sck = 1'b1;
      repeat (3) @(negedge clk);
      sck = 1'b0;
      repeat (3) @(negedge clk);
    end
    do_reset();
    check_val("midrst_regs", {kp, ki, kd, sp}, RST_REGS);
    check_val("midrst_err", 32'(err_cnt), 32'd0);
    repeat (20) @(negedge clk);
    check_val("midrst_regs_late", {kp, ki, kd, sp}, RST_REGS);
    sb_q.push_back(32'h4A23_0022);
    send_frame(32'h0303_0022, 32);
    check_val("midrst_next_sp", 32'(sp), 32'h22);

    // Short frame, bad address, nop, bad opcode, commit ignoring addr
    do_reset();
    send_frame(32'h0100_0011, 31);
    check_val("short_err", 32'(err_cnt), 32'd1);
    send_frame(32'h0104_0011, 32);
    check_val("badaddr_err", 32'(err_cnt), 32'd2);
    check_val("badaddr_regs", {kp, ki, kd, sp}, RST_REGS);
    sb_q.push_back(RST_REGS);
    send_frame(32'h0200_0000, 32);
    send_frame(32'h0000_0000, 32);
    check_val("nop_err", 32'(err_cnt), 32'd2);
    send_frame(32'h0500_0000, 32);
    check_val("badop_err", 32'(err_cnt), 32'd3);
    sb_q.push_back(RST_REGS);
    send_frame(32'h02FF_0000, 32);
    check_val("commit_ffaddr_err", 32'(err_cnt), 32'd3);

    // Saturation of err_cnt
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_frame(32'h0700_0000, 32);
      check_val("sat_err", 32'(err_cnt), (i < 15) ? 32'(i + 1) : 32'd15);
    end

    // Frame arriving during WAIT_COMMIT is dropped
    do_reset();
    pid_busy = 1'b1;
    sb_q.push_back(32'h4A66_0010);
    send_frame(32'h0301_0066, 32);
    send_frame(32'h0100_0099, 32);
    check_val("drop_err", 32'(err_cnt), 32'd1);
    check_val("drop_hold_ki", 32'(ki), 32'h23);
    pid_busy = 1'b0;
    repeat (5) @(negedge clk);
    check_val("drop_ki", 32'(ki), 32'h66);
    check_val("drop_kp", 32'(kp), 32'h4A);
    sb_q.push_back(32'h4A66_0010);
    send_frame(32'h0200_0000, 32);

`ifdef PID_CFG_TIMEOUT_EN
    // Idle sck abort
    do_reset();
    cs = 1'b0;
    repeat (1100) @(negedge clk);
    check_val("tmo_err", 32'(err_cnt), 32'd1);
    check_val("tmo_regs", {kp, ki, kd, sp}, RST_REGS);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    sb_q.push_back(32'h3323_0010);
    send_frame(32'h0300_0033, 32);
    check_val("tmo_next_kp", 32'(kp), 32'h33);
`endif

    repeat (10) @(negedge clk);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
